// File: rtl/text_pkg.sv
// Shared constants and types for the text cursor: grid defaults, control
// characters and the FSM state encoding.
package text_pkg;

  localparam int COLS_DEF      = 80;
  localparam int ROWS_DEF      = 48;
  localparam int INIT_WAIT_DEF = 3740;

  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_SP  = 8'h20;
  localparam logic [7:0] CH_MAX = 8'h7E;

  typedef enum logic [1:0] {
    WAIT_INIT,
    IDLE,
    ROW_CLR
  } state_t;

endpackage

// File: rtl/text_cursor_if.sv
// Byte-in / character-write-out bundle between the byte source, the cursor
// and the text-buffer RAM controller.
interface text_cursor_if import text_pkg::*; #(
  parameter int COLS = COLS_DEF,
  parameter int ROWS = ROWS_DEF
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic [7:0]    char_out;
  logic [RW-1:0] row_out;
  logic [CW-1:0] col_out;
  logic          wr_en;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, char_out, row_out, col_out, wr_en
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, char_out, row_out, col_out, wr_en
  );

endinterface

// File: rtl/cursor_pos.sv
// Row/column cursor over the text grid with end-of-line and bottom-row wrap.
// row_changed flags the command that advances the row this cycle.
module cursor_pos import text_pkg::*; #(
  parameter  int COLS = COLS_DEF,
  parameter  int ROWS = ROWS_DEF,
  localparam int CW   = $clog2(COLS),
  localparam int RW   = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  input  logic          cr,
  input  logic          lf,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic [RW-1:0] row_nxt,
  output logic          row_changed
);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic at_eol;

  assign at_eol      = (col == COL_LAST);
  assign row_changed = lf | (inc & at_eol);
  assign row_nxt     = !row_changed    ? row :
                       (row == ROW_LAST) ? '0  : row + 1'b1;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else begin
      row <= row_nxt;
      if (cr || row_changed)
        col <= '0;
      else if (inc)
        col <= col + 1'b1;
      else if (dec && col != '0)
        col <= col - 1'b1;
    end
  end

endmodule

// File: rtl/text_cursor.sv
// Byte-stream front end of the text-buffer controller: decodes printable and
// CR/LF/BS bytes into character writes and stalls during downstream clears.
module text_cursor import text_pkg::*; #(
  parameter int COLS      = COLS_DEF,
  parameter int ROWS      = ROWS_DEF,
  parameter int INIT_WAIT = INIT_WAIT_DEF,
  parameter int CLR_WAIT  = COLS
) (
  input  logic          clk,
  input  logic          rst,
  text_cursor_if.slave  bus
);

  localparam int CW      = $clog2(COLS);
  localparam int RW      = $clog2(ROWS);
  localparam int CNT_MAX = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(CLR_WAIT - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [RW-1:0]    row_nxt;
  logic             row_changed;
  logic             xfer;
  logic             is_print;
  logic             do_inc;
  logic             do_dec;
  logic             do_cr;
  logic             do_lf;
  logic             bs_write;

  // rx_ready is only high in IDLE, so a transfer implies the IDLE state.
  assign xfer     = bus.rx_valid & bus.rx_ready;
  assign is_print = (bus.rx_data >= CH_SP) && (bus.rx_data <= CH_MAX);
  assign do_inc   = xfer & is_print;
  assign do_dec   = xfer & (bus.rx_data == CH_BS);
  assign do_cr    = xfer & (bus.rx_data == CH_CR);
  assign do_lf    = xfer & (bus.rx_data == CH_LF);
  assign bs_write = do_dec & (col != '0);

  cursor_pos #(.COLS(COLS), .ROWS(ROWS)) u_pos (
    .clk         (clk),
    .rst         (rst),
    .inc         (do_inc),
    .dec         (do_dec),
    .cr          (do_cr),
    .lf          (do_lf),
    .col         (col),
    .row         (row),
    .row_nxt     (row_nxt),
    .row_changed (row_changed)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_INIT;
      wait_cnt     <= '0;
      bus.rx_ready <= 1'b0;
      bus.wr_en    <= 1'b0;
      bus.char_out <= '0;
      bus.row_out  <= '0;
      bus.col_out  <= '0;
    end else begin
      bus.wr_en   <= 1'b0;
      // A write beat reports the pre-advance row; the new row follows a cycle later.
      bus.row_out <= row_nxt;
      case (state)
        WAIT_INIT: begin
          if (wait_cnt == INIT_LAST) begin
            wait_cnt     <= '0;
            state        <= IDLE;
            bus.rx_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        IDLE: begin
          if (do_inc || bs_write) begin
            bus.wr_en    <= 1'b1;
            bus.row_out  <= row;
            bus.char_out <= do_inc ? bus.rx_data : CH_SP;
            bus.col_out  <= do_inc ? col : col - 1'b1;
          end
          if (row_changed) begin
            wait_cnt     <= '0;
            state        <= ROW_CLR;
            bus.rx_ready <= 1'b0;
          end
        end
        ROW_CLR: begin
          if (wait_cnt == CLR_LAST) begin
            wait_cnt     <= '0;
            state        <= IDLE;
            bus.rx_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state        <= WAIT_INIT;
          wait_cnt     <= '0;
          bus.rx_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor.sv
// Randomized scoreboard bench for text_cursor: a grid model predicts each
// character write and the stall lengths; a negedge monitor checks writes.
module tb_text_cursor;
  import text_pkg::*;

  localparam int COLS      = COLS_DEF;
  localparam int ROWS      = ROWS_DEF;
  localparam int INIT_WAIT = INIT_WAIT_DEF;
  localparam int CLR_WAIT  = COLS;

  logic clk = 1'b0;
  logic rst = 1'b1;

  text_cursor_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

  text_cursor #(
    .COLS(COLS), .ROWS(ROWS), .INIT_WAIT(INIT_WAIT), .CLR_WAIT(CLR_WAIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] ch;
    int         row;
    int         col;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks  = 0;
  int  n_fail    = 0;
  int  m_row     = 0;
  int  m_col     = 0;
  int  last_wait = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Monitor: every write beat must match the oldest predicted write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en !== 1'b0) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr: wr_en=%b char=0x%0h row=%0d col=%0d with nothing expected (t=%0t)",
                   bus.wr_en, bus.char_out, bus.row_out, bus.col_out, $time);
        end else begin
          e = exp_q.pop_front();
          check("wr_char", 32'(bus.char_out), 32'(e.ch));
          check("wr_row",  32'(bus.row_out),  e.row);
          check("wr_col",  32'(bus.col_out),  e.col);
        end
      end
    end
  end

  // Counts cycles with rx_ready low, starting #1 after an edge.
  task automatic measure_low(input string name, input int expected);
    int n = 0;
    while (bus.rx_ready !== 1'b1 && n < expected + 20) begin
      n++;
      @(posedge clk);
      #1;
    end
    check(name, n, expected);
  endtask

  // Offers one byte until accepted, then advances the grid model.
  task automatic send_byte(input logic [7:0] b, input bit stall_chk);
    bit acc;
    bit adv = 1'b0;
    int waited = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    do begin
      acc = (bus.rx_ready === 1'b1);
      @(posedge clk);
      #1;
      waited++;
    end while (!acc && waited < 5000);
    bus.rx_valid = 1'b0;
    last_wait    = waited;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: byte 0x%0h not accepted after %0d cycles", b, waited);
      return;
    end
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back('{b, m_row, m_col});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        adv   = 1'b1;
      end
    end else if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      adv   = 1'b1;
    end else if (b == 8'h08 && m_col > 0) begin
      m_col--;
      exp_q.push_back('{8'h20, m_row, m_col});
    end
    if (adv) begin
      m_row = (m_row + 1) % ROWS;
      if (stall_chk) begin
        measure_low("row_clr_stall", CLR_WAIT);
        check("row_after_adv", 32'(bus.row_out), m_row);
      end
    end
  endtask

  // Reset for one edge, check reset values, then hold rx_valid through init.
  task automatic do_reset();
    bus.rx_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rx_ready", 32'(bus.rx_ready), 0);
    check("rst_wr_en",    32'(bus.wr_en),    0);
    check("rst_char_out", 32'(bus.char_out), 0);
    check("rst_row_out",  32'(bus.row_out),  0);
    check("rst_col_out",  32'(bus.col_out),  0);
    rst   = 1'b0;
    m_row = 0;
    m_col = 0;
    exp_q.delete();
    bus.rx_data  = 8'h41;
    bus.rx_valid = 1'b1;
    measure_low("init_wait", INIT_WAIT);
    bus.rx_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    do_reset();

    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    check("b2b_accept", last_wait, 1);

    send_byte(8'h07, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h43, 1'b1);

    send_byte(8'h0D, 1'b1);
    for (int i = 0; i < COLS; i++)
      send_byte(8'($urandom_range(32, 126)), 1'b1);
    send_byte(8'h44, 1'b1);

    send_byte(8'h0D, 1'b1);
    send_byte(8'h58, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h08, 1'b1);
    send_byte(8'h59, 1'b1);

    while (m_row != ROWS - 1)
      send_byte(8'h0A, 1'b1);
    send_byte(8'h0A, 1'b1);
    check("lf_wrap_col", m_col, 0);

    for (int i = 0; i < 250; i++) begin
      r = $urandom_range(0, 99);
      if (r < 70)      send_byte(8'($urandom_range(32, 126)), 1'b1);
      else if (r < 78) send_byte(8'h08, 1'b1);
      else if (r < 83) send_byte(8'h0D, 1'b1);
      else if (r < 87) send_byte(8'h0A, 1'b1);
      else             send_byte(8'($urandom_range(0, 255)), 1'b1);
      if ($urandom_range(0, 3) == 0)
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
    end

    send_byte(8'h0A, 1'b0);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    do_reset();
    send_byte(8'h51, 1'b1);
    send_byte(8'h52, 1'b1);

    repeat (5) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
